// File: rtl/pool_src_buffer_if.sv
// Stream, handshake and window-read bundle between the pixel source, pool_src_buffer and the pooling engine.
// Optional SRC_CHECKSUM_EN adds the frame_sum signal.
interface pool_src_buffer_if #(
  parameter int CNT_W = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 ready;
  logic                 busy;
  logic                 ren;
  logic [2*CNT_W-1:0]   caddr_rd;
  logic [15:0]          cdata_rd0;
  logic [15:0]          cdata_rd1;
  logic [15:0]          cdata_rd2;
  logic [15:0]          cdata_rd3;
  logic [15:0]          cdata_rd4;
  logic [15:0]          cdata_rd5;
  logic [15:0]          cdata_rd6;
  logic [15:0]          cdata_rd7;
  logic [7:0]           frame_cnt;
  logic                 rd_err;
`ifdef SRC_CHECKSUM_EN
  logic [15:0]          frame_sum;
`endif

  modport master (
    output in_valid, in_data, busy, ren, caddr_rd,
    input  in_ready, ready, cdata_rd0, cdata_rd1, cdata_rd2, cdata_rd3,
           cdata_rd4, cdata_rd5, cdata_rd6, cdata_rd7, frame_cnt, rd_err
`ifdef SRC_CHECKSUM_EN
    , input frame_sum
`endif
  );

  modport slave (
    input  in_valid, in_data, busy, ren, caddr_rd,
    output in_ready, ready, cdata_rd0, cdata_rd1, cdata_rd2, cdata_rd3,
           cdata_rd4, cdata_rd5, cdata_rd6, cdata_rd7, frame_cnt, rd_err
`ifdef SRC_CHECKSUM_EN
    , output frame_sum
`endif
  );
endinterface

// File: rtl/pool_src_buffer.sv
// Frame buffer ahead of the maxpooling engine: loads a SIZE x SIZE raster image, then serves 4x4 windows.
// Define SRC_CHECKSUM_EN to add the frame_sum output.
//
// state | meaning
// LOAD  | accepting pixels into the frame buffer
// ARMED | frame complete, ready=1, waiting for busy
// SERVE | pooling engine reading windows until busy drops
module pool_src_buffer #(
  parameter int SIZE  = 128,
  parameter int CNT_W = 7
) (
  input logic               clk,
  input logic               rst,
  pool_src_buffer_if.slave  bus
);
  localparam int AW = 2 * CNT_W;

  typedef enum logic [1:0] {LOAD, ARMED, SERVE} state_t;

  state_t         state;
  logic [AW-1:0]  wp;
  logic [7:0]     mem [SIZE*SIZE];
  logic [7:0]     win [16];
  logic           accept;
  logic           last;

  assign accept = (state == LOAD) && bus.in_ready && bus.in_valid;
  assign last   = (wp == {AW{1'b1}});

  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= bus.in_data;
  end

  // Index arithmetic is AW bits wide, so windows past the end wrap to the frame start.
  always_comb begin
    for (int dr = 0; dr < 4; dr++)
      for (int dc = 0; dc < 4; dc++)
        win[dr*4+dc] = mem[bus.caddr_rd + AW'(dr*SIZE + dc)];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= LOAD;
      wp            <= '0;
      bus.in_ready  <= 1'b0;
      bus.ready     <= 1'b0;
      bus.frame_cnt <= '0;
      bus.rd_err    <= 1'b0;
      bus.cdata_rd0 <= '0;
      bus.cdata_rd1 <= '0;
      bus.cdata_rd2 <= '0;
      bus.cdata_rd3 <= '0;
      bus.cdata_rd4 <= '0;
      bus.cdata_rd5 <= '0;
      bus.cdata_rd6 <= '0;
      bus.cdata_rd7 <= '0;
    end else begin
      case (state)
        LOAD: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            wp <= wp + 1'b1;
            if (last) begin
              state        <= ARMED;
              bus.in_ready <= 1'b0;
              bus.ready    <= 1'b1;
            end
          end
        end
        ARMED: begin
          if (bus.busy) begin
            state     <= SERVE;
            bus.ready <= 1'b0;
          end
        end
        SERVE: begin
          if (!bus.busy) begin
            state         <= LOAD;
            bus.in_ready  <= 1'b1;
            bus.frame_cnt <= bus.frame_cnt + 8'd1;
          end
        end
        default: state <= LOAD;
      endcase

      if (bus.ren) begin
        if (state == SERVE) begin
          bus.cdata_rd0 <= {win[0],  win[1]};
          bus.cdata_rd1 <= {win[4],  win[5]};
          bus.cdata_rd2 <= {win[8],  win[9]};
          bus.cdata_rd3 <= {win[12], win[13]};
          bus.cdata_rd4 <= {win[2],  win[3]};
          bus.cdata_rd5 <= {win[6],  win[7]};
          bus.cdata_rd6 <= {win[10], win[11]};
          bus.cdata_rd7 <= {win[14], win[15]};
        end else begin
          bus.rd_err    <= 1'b1;
          bus.cdata_rd0 <= '0;
          bus.cdata_rd1 <= '0;
          bus.cdata_rd2 <= '0;
          bus.cdata_rd3 <= '0;
          bus.cdata_rd4 <= '0;
          bus.cdata_rd5 <= '0;
          bus.cdata_rd6 <= '0;
          bus.cdata_rd7 <= '0;
        end
      end
    end
  end

`ifdef SRC_CHECKSUM_EN
  // The first pixel of a frame restarts the sum, so the value holds through ARMED and SERVE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.frame_sum <= '0;
    end else if (accept) begin
      if (wp == '0) bus.frame_sum <= {8'd0, bus.in_data};
      else          bus.frame_sum <= bus.frame_sum + {8'd0, bus.in_data};
    end
  end
`endif

endmodule

// File: tb/tb_pool_src_buffer.sv
// Directed bench for pool_src_buffer at SIZE=8: load, window reads, wrap, throttling, rd_err and reset.
module tb_pool_src_buffer;
  localparam int SIZE  = 8;
  localparam int CNT_W = 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   idx;
  int   cyc;
  logic take;

  pool_src_buffer_if #(.CNT_W(CNT_W)) bus ();

  pool_src_buffer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    bus.busy     = 1'b0;
    bus.ren      = 1'b0;
    bus.caddr_rd = '0;
    #12;
    chk("rst_ready",    32'(bus.ready), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_cdata0",   32'(bus.cdata_rd0), 32'd0);
    chk("rst_fcnt",     32'(bus.frame_cnt), 32'd0);
    chk("rst_rd_err",   32'(bus.rd_err), 32'd0);
    rst = 1'b1;
    step();
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // frame 1: P[i] = i, valid held high
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      step();
      if (i == 62) chk("ready_before_last", 32'(bus.ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("f1_ready",    32'(bus.ready), 32'd1);
    chk("f1_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef SRC_CHECKSUM_EN
    chk("f1_sum", 32'(bus.frame_sum), 32'h07E0);
`endif
    bus.busy = 1'b1;
    step();
    chk("serve_ready_low", 32'(bus.ready), 32'd0);

    bus.ren = 1'b1;
    bus.caddr_rd = 6'd18;
    step();
    chk("w18_rd0", 32'(bus.cdata_rd0), 32'h1213);
    chk("w18_rd1", 32'(bus.cdata_rd1), 32'h1A1B);
    chk("w18_rd3", 32'(bus.cdata_rd3), 32'h2A2B);
    chk("w18_rd4", 32'(bus.cdata_rd4), 32'h1415);
    chk("w18_rd7", 32'(bus.cdata_rd7), 32'h2C2D);
    bus.caddr_rd = 6'd60;
    step();
    chk("w60_rd0", 32'(bus.cdata_rd0), 32'h3C3D);
    chk("w60_rd4", 32'(bus.cdata_rd4), 32'h3E3F);
    chk("w60_rd1", 32'(bus.cdata_rd1), 32'h0405);
    chk("w60_rd7", 32'(bus.cdata_rd7), 32'h1617);
    bus.ren = 1'b0;
    bus.caddr_rd = 6'd0;
    step();
    chk("hold_rd0", 32'(bus.cdata_rd0), 32'h3C3D);
    chk("fcnt_in_serve", 32'(bus.frame_cnt), 32'd0);
    bus.busy = 1'b0;
    step();
    chk("fcnt_after_busy", 32'(bus.frame_cnt), 32'd1);
    chk("reload_in_ready", 32'(bus.in_ready), 32'd1);

    // read request while loading
    bus.ren = 1'b1;
    step();
    bus.ren = 1'b0;
    chk("load_ren_rd0", 32'(bus.cdata_rd0), 32'd0);
    chk("load_ren_rd7", 32'(bus.cdata_rd7), 32'd0);
    chk("load_ren_err", 32'(bus.rd_err), 32'd1);

    // frame 2: P[i] = ~i, throttled valid
    idx = 0;
    cyc = 0;
    while (idx < 64 && cyc < 1000) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = ~8'(idx);
      take = bus.in_valid && bus.in_ready;
      step();
      if (take) idx++;
      cyc++;
    end
    chk("f2_count", 32'(idx), 32'd64);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    step();
    step();
    step();
    chk("armed_in_ready", 32'(bus.in_ready), 32'd0);
    chk("armed_ready",    32'(bus.ready), 32'd1);
    chk("armed_fcnt",     32'(bus.frame_cnt), 32'd1);
`ifdef SRC_CHECKSUM_EN
    chk("f2_sum", 32'(bus.frame_sum), 32'h37E0);
`endif
    bus.in_valid = 1'b0;
    bus.busy = 1'b1;
    step();
    bus.ren = 1'b1;
    bus.caddr_rd = 6'd0;
    step();
    chk("f2_w0_rd0", 32'(bus.cdata_rd0), 32'hFFFE);
    chk("f2_w0_rd1", 32'(bus.cdata_rd1), 32'hF7F6);
    chk("f2_w0_rd3", 32'(bus.cdata_rd3), 32'hE7E6);
    bus.caddr_rd = 6'd63;
    bus.busy = 1'b0;
    step();
    bus.ren = 1'b0;
    chk("f2_w63_rd0", 32'(bus.cdata_rd0), 32'hC0FF);
    chk("f2_fcnt",    32'(bus.frame_cnt), 32'd2);
    chk("err_sticky", 32'(bus.rd_err), 32'd1);

    // frame 3: all 0xFF
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      step();
    end
    bus.in_valid = 1'b0;
    chk("f3_ready", 32'(bus.ready), 32'd1);
`ifdef SRC_CHECKSUM_EN
    chk("f3_sum", 32'(bus.frame_sum), 32'h3FC0);
`endif
    bus.busy = 1'b1;
    step();
    bus.ren = 1'b1;
    bus.caddr_rd = 6'd5;
    step();
    bus.ren = 1'b0;
    chk("f3_rd5", 32'(bus.cdata_rd5), 32'hFFFF);

    // asynchronous reset mid-serve
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rd5",  32'(bus.cdata_rd5), 32'd0);
    chk("mid_rst_fcnt", 32'(bus.frame_cnt), 32'd0);
    chk("mid_rst_err",  32'(bus.rd_err), 32'd0);
    chk("mid_rst_inr",  32'(bus.in_ready), 32'd0);
    bus.busy = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("post_rst_inr", 32'(bus.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_src_buffer.md
Name: pool_src_buffer

Overview:
- Upstream input stage for the maxpooling engine.
- Accepts one raster-order 8-bit image of SIZE x SIZE pixels over a valid/ready stream and stores it in an internal frame buffer.
- Asserts `ready` to start pooling, then serves 4x4 window reads on `ren`/`caddr_rd`, returning 16 pixels per access on `cdata_rd0..7`.
- Returns to loading once the pooling engine drops `busy`.

Parameters:
- SIZE, 128, image width and height in pixels; power of two, at least 4.
- CNT_W, 7, log2(SIZE); sets address width 2*CNT_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  buffer can accept a pixel.
- in_data  in  8  pixel value, raster order (row-major, row 0 first).
- ready  out  1  frame loaded, pooling may start.
- busy  in  1  pooling engine active.
- ren  in  1  window read request.
- caddr_rd  in  2*CNT_W  linear index of window top-left pixel (row*SIZE+col).
- cdata_rd0..cdata_rd3  out  16 each  rows +0..+3 at columns +0,+1: {P[r][c], P[r][c+1]}.
- cdata_rd4..cdata_rd7  out  16 each  rows +0..+3 at columns +2,+3: {P[r][c+2], P[r][c+3]}.
- frame_cnt  out  8  frames completed; wraps 255->0.
- rd_err  out  1  sticky: `ren` seen outside SERVE.

Behaviour:
Reset (rst=0, asynchronous):
- State LOAD, write pointer 0.
- `ready`=0, all `cdata_rd*`=0, `frame_cnt`=0, `rd_err`=0.
- `in_ready`=1 from the first edge after rst rises; buffer contents are not cleared.

State LOAD:
- `in_ready`=1.
- Each edge with `in_valid`=1 writes `in_data` to buf[wp] and increments wp.
- When the pixel at wp=SIZE*SIZE-1 is accepted: wp returns to 0, next state ARMED.

State ARMED:
- `in_ready`=0, `ready`=1 from the cycle after the last pixel is accepted.
- On an edge with `busy`=1: `ready`->0 on that edge, next state SERVE.
- `busy` may rise in the same cycle `ready` first goes high.

State SERVE:
- `in_ready`=0.
- Each edge with `ren`=1 registers the 16 window pixels onto `cdata_rd0..7`. Latency: data valid from that edge until the next update; back-to-back reads every cycle are supported.
- Edges with `ren`=0: `cdata_rd*` hold their values.
- On an edge with `busy`=0: `frame_cnt`+1, next state LOAD. A `ren` on that same edge is still served.

Window addressing:
- Pixel offset (dr,dc) is read at index (caddr_rd + dr*SIZE + dc) modulo SIZE*SIZE, i.e. truncated to 2*CNT_W bits.
- Windows that overrun the last row or column wrap linearly; no error is raised for this.
- Upper byte of each 16-bit word = lower column index.

Outside SERVE:
- `ren`=1 in LOAD or ARMED: `cdata_rd*` forced to 0 and `rd_err` set; `rd_err` clears only on reset.

Other rules:
- `in_valid` while `in_ready`=0 is ignored (pixel not consumed).
- Reset asserted mid-load or mid-serve aborts immediately. The next frame restarts at wp=0; earlier partial data is overwritten as loading proceeds.

Optional Feature:
- Macro SRC_CHECKSUM_EN.
- Defined: adds output port `frame_sum` [15:0]. It is the modulo-2^16 sum of all pixels accepted in the current/last frame, cleared to 0 on reset and on the first pixel of each new frame (that pixel's value is loaded). The value is held stable from ARMED through SERVE.
- Undefined: no port, no adder; behaviour is otherwise identical.

Test Plan:
1. SIZE=8, CNT_W=3, load pixels P[i]=i (0..63) with `in_valid` held high -> `in_ready` drops and `ready`=1 on the cycle after pixel 63; raise `busy` -> `ready`=0 next edge.
2. In SERVE, `ren`=1, `caddr_rd`=18 -> next cycle `cdata_rd0`=16'h1213, `cdata_rd1`=16'h1A1B, `cdata_rd3`=16'h2A2B, `cdata_rd4`=16'h1415, `cdata_rd7`=16'h2C2D.
3. Wrap case: `caddr_rd`=60 -> `cdata_rd0`=16'h3C3D, `cdata_rd4`=16'h3E3F, `cdata_rd1`=16'h0405 (index 68 mod 64=4).
4. Throttling: `in_valid` toggled 1,0,1 with random gaps; `in_valid`=1 driven during ARMED -> exactly 64 pixels stored, extra ignored, `frame_cnt` increments only when `busy` falls.
5. `ren`=1 during LOAD -> `cdata_rd*`=0 and `rd_err`=1, staying 1 through the following frame; rst=0 mid-SERVE -> all outputs 0 immediately, `in_ready`=1 after release.
6. With SRC_CHECKSUM_EN, P[i]=i -> `frame_sum`=16'h07E0 (2016); second frame of all 8'hFF -> 16'h3FC0.
